// File: rtl/bus_cycle_responder_pkg.sv
// Shared encodings for the k30p local bus cycle responder: DSACK port-size
// codes, active-low signal levels, responder states and counter sizing.
package k30p_bus_pkg;

  // {DSACK1, DSACK0} as driven to the 68030.
  localparam logic [1:0] DSACK_32   = 2'b00;
  localparam logic [1:0] DSACK_16   = 2'b01;
  localparam logic [1:0] DSACK_8    = 2'b10;
  localparam logic [1:0] DSACK_NONE = 2'b11;

  // All strobes, requests and acknowledges on this bus are active-low.
  localparam logic ACTIVE   = 1'b0;
  localparam logic INACTIVE = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    VME,
    ACK,
    ERROR
  } resp_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bus_cycle_responder_if.sv
// CPU-side bus signals seen by the cycle responder. The master modport is the
// CPU/decoder/VME-bridge side; the slave modport is the responder.
//
// Handshake: a cycle is open while cpu_as is low. The responder terminates
// it by asserting exactly one of cpu_dsack (port size) or cpu_berr, holds that
// termination until cpu_as is seen high, then negates. A new cycle is only
// accepted after cpu_as has been seen high for at least one clock edge.
interface bus_cycle_responder_if;
  import k30p_bus_pkg::*;

  logic       cpu_as;
  logic       request_rom;
  logic       request_ram;
  logic       request_serial;
  logic       request_vme_a16;
  logic       request_vme_a24;
  logic       request_vme_a40;
  logic       request_unmapped;
  logic       vme_dtack;
  logic       vme_berr;
  logic [1:0] cpu_dsack;
  logic       cpu_berr;

  modport master (
    output cpu_as, request_rom, request_ram, request_serial,
           request_vme_a16, request_vme_a24, request_vme_a40,
           request_unmapped, vme_dtack, vme_berr,
    input  cpu_dsack, cpu_berr
  );

  modport slave (
    input  cpu_as, request_rom, request_ram, request_serial,
           request_vme_a16, request_vme_a24, request_vme_a40,
           request_unmapped, vme_dtack, vme_berr,
    output cpu_dsack, cpu_berr
  );

endinterface

// File: rtl/bus_cycle_responder_sync_2ff.sv
// Two-flop synchronizer for one active-low asynchronous input. Resets to the
// inactive (high) level so nothing looks asserted coming out of reset.
module sync_2ff
  import k30p_bus_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta <= INACTIVE;
      q    <= INACTIVE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bus_cycle_responder.sv
// Terminates every k30p local CPU bus cycle: per-target wait states for local
// devices, synchronized VME acknowledge/error, and a watchdog that turns
// unmapped or hung cycles into a bus error. Outputs are registered.
module bus_cycle_responder
  import k30p_bus_pkg::*;
#(
  parameter int ROM_WAIT    = 2,
  parameter int RAM_WAIT    = 1,
  parameter int SERIAL_WAIT = 3,
  parameter int TIMEOUT     = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  bus_cycle_responder_if.slave  bus,
  output resp_state_e           state_dbg
);

  localparam int MAX_WAIT = max3(ROM_WAIT, RAM_WAIT, SERIAL_WAIT);
  localparam int WAIT_W   = cnt_width(MAX_WAIT);
  localparam int WD_W     = cnt_width(TIMEOUT);

  resp_state_e       state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WD_W-1:0]   wd_cnt;
  logic [1:0]        size_q;
  logic [1:0]        dsack_q;
  logic              berr_q;
  logic              dtack_s;
  logic              berr_s;
  logic              any_vme;
  logic              wd_expired;

  sync_2ff u_sync_dtack (
    .clock (clock),
    .reset (reset),
    .d     (bus.vme_dtack),
    .q     (dtack_s)
  );

  sync_2ff u_sync_berr (
    .clock (clock),
    .reset (reset),
    .d     (bus.vme_berr),
    .q     (berr_s)
  );

  assign any_vme    = (bus.request_vme_a16 == ACTIVE) ||
                      (bus.request_vme_a24 == ACTIVE) ||
                      (bus.request_vme_a40 == ACTIVE);
  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT));

  // Responder FSM with registered DSACK/BERR. A cycle with no matching
  // request enters WAIT with DSACK_NONE latched, so only the watchdog ends it.
  // Unmapped cycles enter ERROR and raise BERR on the following edge, giving
  // them the same one-edge latency as a zero-wait local access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      wd_cnt   <= '0;
      size_q   <= DSACK_NONE;
      dsack_q  <= DSACK_NONE;
      berr_q   <= INACTIVE;
    end else begin
      case (state)
        IDLE: begin
          wd_cnt  <= '0;
          dsack_q <= DSACK_NONE;
          berr_q  <= INACTIVE;
          if (bus.cpu_as == ACTIVE) begin
            if (bus.request_rom == ACTIVE) begin
              wait_cnt <= WAIT_W'(ROM_WAIT);
              size_q   <= DSACK_16;
              state    <= WAIT;
            end else if (bus.request_ram == ACTIVE) begin
              wait_cnt <= WAIT_W'(RAM_WAIT);
              size_q   <= DSACK_32;
              state    <= WAIT;
            end else if (bus.request_serial == ACTIVE) begin
              wait_cnt <= WAIT_W'(SERIAL_WAIT);
              size_q   <= DSACK_8;
              state    <= WAIT;
            end else if (any_vme) begin
              size_q   <= DSACK_16;
              state    <= VME;
            end else if (bus.request_unmapped == ACTIVE) begin
              state    <= ERROR;
            end else begin
              wait_cnt <= '0;
              size_q   <= DSACK_NONE;
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.cpu_as == INACTIVE) begin
            state <= IDLE;
          end else if (wd_expired) begin
            berr_q <= ACTIVE;
            state  <= ERROR;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wait_cnt == '0) begin
              if (size_q != DSACK_NONE) begin
                dsack_q <= size_q;
                state   <= ACK;
              end
            end else begin
              wait_cnt <= wait_cnt - 1'b1;
            end
          end
        end
        VME: begin
          if (bus.cpu_as == INACTIVE) begin
            state <= IDLE;
          end else if (wd_expired) begin
            berr_q <= ACTIVE;
            state  <= ERROR;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
            if (berr_s == ACTIVE) begin
              berr_q <= ACTIVE;
              state  <= ERROR;
            end else if (dtack_s == ACTIVE) begin
              dsack_q <= DSACK_16;
              state   <= ACK;
            end
          end
        end
        ACK: begin
          if (bus.cpu_as == INACTIVE) begin
            dsack_q <= DSACK_NONE;
            state   <= IDLE;
          end
        end
        ERROR: begin
          dsack_q <= DSACK_NONE;
          if (bus.cpu_as == INACTIVE) begin
            berr_q <= INACTIVE;
            state  <= IDLE;
          end else begin
            berr_q <= ACTIVE;
          end
        end
        default: begin
          dsack_q <= DSACK_NONE;
          berr_q  <= INACTIVE;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.cpu_dsack = dsack_q;
  assign bus.cpu_berr  = berr_q;
  assign state_dbg     = state;

endmodule
